// File: rtl/led_pwm_if.sv
// led_pwm control/status bundle.
// Master drives target duty and mode; slave reports PWM state.
interface led_pwm_if #(
  parameter int DUTY_W = 8
);
  logic [DUTY_W-1:0] duty_in;
  logic              fade_en;
  logic              pwm_out;
  logic              period_end;
  logic [DUTY_W-1:0] duty_cur;
  logic              busy;

  modport master (
    output duty_in,
    output fade_en,
    input  pwm_out,
    input  period_end,
    input  duty_cur,
    input  busy
  );

  modport slave (
    input  duty_in,
    input  fade_en,
    output pwm_out,
    output period_end,
    output duty_cur,
    output busy
  );
endinterface

// File: rtl/led_pwm.sv
// LED PWM with period-aligned duty updates and optional fade.
// Duty moves only at the period boundary so no mid-period glitches.
module led_pwm #(
  parameter int DUTY_W = 8,
  parameter int PRESC  = 4
) (
  input logic     clk,
  input logic     rst,
  led_pwm_if.slave bus
);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);
  localparam logic [DUTY_W-1:0] PCNT_LAST =
    {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PW-1:0]     pre;
  logic [DUTY_W-1:0] pcnt;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_nxt;
  logic              pwm_q;
  logic              pe_q;
  logic              busy_q;
  logic              tick;
  logic              boundary;

  // Tick and period-boundary detection.
  always_comb begin
    tick     = (pre == PRE_LAST);
    boundary = tick && (pcnt == PCNT_LAST);
  end

  // Duty to apply after this clock: jump or one-LSB step.
  always_comb begin
    duty_nxt = duty_q;
    if (boundary) begin
      if (!bus.fade_en)
        duty_nxt = bus.duty_in;
      else if (bus.duty_in > duty_q)
        duty_nxt = duty_q + 1'b1;
      else if (bus.duty_in < duty_q)
        duty_nxt = duty_q - 1'b1;
    end
  end

  // Prescaler and period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      pcnt <= '0;
    end else if (tick) begin
      pre  <= '0;
      pcnt <= boundary ? '0 : pcnt + 1'b1;
    end else begin
      pre  <= pre + PW'(1);
    end
  end

  // Applied duty, output compare, period pulse and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
      pe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      duty_q <= duty_nxt;
      pwm_q  <= (pcnt < duty_q);
      pe_q   <= boundary;
      busy_q <= bus.fade_en && (duty_nxt != bus.duty_in);
    end
  end

  assign bus.duty_cur   = duty_q;
  assign bus.pwm_out    = pwm_q;
  assign bus.period_end = pe_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_led_pwm.sv
// Bench for led_pwm: timeline model plus directed period checks.
// PRESC=2, DUTY_W=8, so one period is 510 clocks.
module tb_led_pwm;
  localparam int W     = 8;
  localparam int PRESC = 2;
  localparam int PER   = ((1 << W) - 1) * PRESC;

  logic clk = 1'b0;
  logic rst;
  bit   run_cmp = 1'b0;

  int checks   = 0;
  int failures = 0;
  int hi_acc   = 0;
  int clk_acc  = 0;

  always #5 clk = ~clk;

  led_pwm_if #(.DUTY_W(W)) bus ();

  led_pwm #(
    .DUTY_W(W),
    .PRESC (PRESC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Timeline model: e = clocks since reset release.
  // State after m clocks sits at tick index (m mod PER)/PRESC,
  // and every PER-th clock closes a period.
  int e;
  int m_duty;
  bit m_pwm, m_pe, m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0; m_duty = 0;
      m_pwm = 0; m_pe = 0; m_busy = 0;
    end else begin
      m_pwm = (((e % PER) / PRESC) < m_duty);
      e++;
      m_pe = ((e % PER) == 0);
      if (m_pe) begin
        if (!bus.fade_en) m_duty = int'(bus.duty_in);
        else if (int'(bus.duty_in) > m_duty) m_duty++;
        else if (int'(bus.duty_in) < m_duty) m_duty--;
      end
      m_busy = bus.fade_en && (m_duty != int'(bus.duty_in));
    end
  end

  // Per-clock comparison against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("pwm_out",    32'(bus.pwm_out),    32'(m_pwm));
      chk("period_end", 32'(bus.period_end), 32'(m_pe));
      chk("duty_cur",   32'(bus.duty_cur),   32'(m_duty));
      chk("busy",       32'(bus.busy),       32'(m_busy));
    end
  end

  task automatic step();
    @(negedge clk);
    clk_acc++;
    if (bus.pwm_out === 1'b1) hi_acc++;
  endtask

  task automatic clr();
    hi_acc  = 0;
    clk_acc = 0;
  endtask

  task automatic wait_pe();
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.period_end !== 1'b1 && n < 2 * PER);
    chk("pe_seen", 32'(bus.period_end), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.duty_in = '0;
    bus.fade_en = 1'b0;
    #1 run_cmp = 1'b1;
    #11;
    chk("rst_pwm",  32'(bus.pwm_out),    32'd0);
    chk("rst_pe",   32'(bus.period_end), 32'd0);
    chk("rst_duty", 32'(bus.duty_cur),   32'd0);
    chk("rst_busy", 32'(bus.busy),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Duty 0 for three periods.
    for (int p = 0; p < 3; p++) begin
      clr();
      wait_pe();
      chk("t1_gap", 32'(clk_acc), 32'(PER));
      chk("t1_hi",  32'(hi_acc),  32'd0);
    end
    chk("t1_duty", 32'(bus.duty_cur), 32'd0);

    // Full on.
    bus.duty_in = 8'd255;
    wait_pe();
    chk("t2_duty", 32'(bus.duty_cur), 32'd255);
    clr();
    wait_pe();
    chk("t2_hi", 32'(hi_acc), 32'(PER));

    // Duty 64.
    bus.duty_in = 8'd64;
    wait_pe();
    clr();
    wait_pe();
    chk("t3_hi",  32'(hi_acc),  32'd128);
    chk("t3_gap", 32'(clk_acc), 32'(PER));

    // Mid-period change is deferred to the boundary.
    clr();
    repeat (200) step();
    chk("t4_hold", 32'(bus.duty_cur), 32'd64);
    bus.duty_in = 8'd200;
    step();
    chk("t4_hold2", 32'(bus.duty_cur), 32'd64);
    wait_pe();
    chk("t4_hi_old", 32'(hi_acc),       32'd128);
    chk("t4_duty",   32'(bus.duty_cur), 32'd200);
    clr();
    wait_pe();
    chk("t4_hi_new", 32'(hi_acc), 32'd400);

    // Fade 0 -> 3 -> 1.
    bus.duty_in = 8'd0;
    wait_pe();
    chk("t5_zero", 32'(bus.duty_cur), 32'd0);
    bus.fade_en = 1'b1;
    bus.duty_in = 8'd3;
    step();
    chk("t5_busy0", 32'(bus.busy), 32'd1);
    wait_pe();
    chk("t5_d1", 32'(bus.duty_cur), 32'd1);
    chk("t5_b1", 32'(bus.busy),     32'd1);
    wait_pe();
    chk("t5_d2", 32'(bus.duty_cur), 32'd2);
    wait_pe();
    chk("t5_d3", 32'(bus.duty_cur), 32'd3);
    chk("t5_b3", 32'(bus.busy),     32'd0);
    bus.duty_in = 8'd1;
    step();
    chk("t5_busy_dn", 32'(bus.busy), 32'd1);
    wait_pe();
    chk("t5_dn2", 32'(bus.duty_cur), 32'd2);
    wait_pe();
    chk("t5_dn1", 32'(bus.duty_cur), 32'd1);
    chk("t5_bdn", 32'(bus.busy),     32'd0);

    // Async reset mid-period.
    bus.fade_en = 1'b0;
    bus.duty_in = 8'd64;
    wait_pe();
    chk("t6_duty", 32'(bus.duty_cur), 32'd64);
    repeat (300) step();
    #2 rst = 1'b1;
    #1;
    chk("t6_pwm",  32'(bus.pwm_out),    32'd0);
    chk("t6_pe",   32'(bus.period_end), 32'd0);
    chk("t6_duty0",32'(bus.duty_cur),   32'd0);
    chk("t6_busy", 32'(bus.busy),       32'd0);
    bus.duty_in = 8'd100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
    wait_pe();
    chk("t6_gap",  32'(clk_acc),      32'(PER));
    chk("t6_hi0",  32'(hi_acc),       32'd0);
    chk("t6_reap", 32'(bus.duty_cur), 32'd100);
    clr();
    wait_pe();
    chk("t6_hi", 32'(hi_acc), 32'd200);

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
